// File: rtl/tt_sel_driver_if.sv
// tt_sel_driver_if: request handshake, status and select-pad signals of tt_sel_driver.
interface tt_sel_driver_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ena;
   logic              busy;
   logic              done;
   logic              ctrl_sel_rst_n;
   logic              ctrl_sel_inc;
   logic              ctrl_ena;
   modport master (
      output req_valid, req_addr, req_ena,
      input  req_ready, busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
   );
   modport slave (
      input  req_valid, req_addr, req_ena,
      output req_ready, busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
   );
endinterface

// File: rtl/tt_sel_driver.sv
// tt_sel_driver: drives the design-select pads through disable, counter reset,
// N increment pulses and optional enable; every pad output is registered.
module tt_sel_driver #(
   parameter int ADDR_W    = 10,
   parameter int PULSE_CYC = 4
) (
   input  logic           clk,
   input  logic           rst,
   tt_sel_driver_if.slave bus
);
   localparam int TW = $clog2(PULSE_CYC + 1);
   typedef enum logic [2:0] {IDLE, DISABLE, SELRST, RELEASE, INC_HI, INC_LO, FINISH} state_t;
   state_t            r_state, w_state_n;
   logic [TW-1:0]     r_timer;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_ena_lat, r_rst_n, r_inc, r_ena, r_done, r_busy, r_ready;
   logic              w_acc, w_tdone, w_rst_n, w_inc, w_ena, w_done, w_ready;
   assign w_acc   = bus.req_valid && (r_state == IDLE || r_state == FINISH);
   assign w_tdone = r_timer == '0;
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE:    if (w_acc) w_state_n = DISABLE;
         DISABLE: if (w_tdone) w_state_n = SELRST;
         SELRST:  if (w_tdone) w_state_n = RELEASE;
         RELEASE: if (w_tdone) w_state_n = (r_cnt == '0) ? FINISH : INC_HI;
         INC_HI:  if (w_tdone) w_state_n = INC_LO;
         INC_LO:  if (w_tdone) w_state_n = (r_cnt == ADDR_W'(1)) ? FINISH : INC_HI;
         FINISH:  w_state_n = w_acc ? DISABLE : IDLE;
         default: w_state_n = IDLE;
      endcase
      // pads are registered from the next state so they change exactly on state edges
      w_rst_n = (w_state_n == SELRST) ? 1'b0 : (w_state_n == IDLE) ? r_rst_n : 1'b1;
      w_inc   = w_state_n == INC_HI;
      w_ena   = (w_state_n == FINISH) ? r_ena_lat : (w_state_n == IDLE) ? r_ena : 1'b0;
      w_done  = w_state_n == FINISH;
      w_ready = w_state_n == IDLE || w_state_n == FINISH;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_cnt     <= '0;
         r_ena_lat <= 1'b0;
         r_rst_n   <= 1'b0;
         r_inc     <= 1'b0;
         r_ena     <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_timer <= (w_state_n != r_state) ? TW'(PULSE_CYC - 1) : w_tdone ? r_timer : r_timer - TW'(1);
         if (w_acc) begin
            r_cnt     <= bus.req_addr;
            r_ena_lat <= bus.req_ena;
         end else if (r_state == INC_LO && w_tdone) begin
            r_cnt <= r_cnt - ADDR_W'(1);
         end
         r_rst_n <= w_rst_n;
         r_inc   <= w_inc;
         r_ena   <= w_ena;
         r_done  <= w_done;
         r_busy  <= !w_ready;
         r_ready <= w_ready;
      end
   end
   assign bus.req_ready      = r_ready;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.ctrl_sel_rst_n = r_rst_n;
   assign bus.ctrl_sel_inc   = r_inc;
   assign bus.ctrl_ena       = r_ena;
endmodule

// File: tb/tb_tt_sel_driver.sv
// tb_tt_sel_driver: directed vectors on a P=4/ADDR_W=10 instance and a P=1/ADDR_W=4 instance,
// plus back-to-back, async-reset and pad-protocol checks.
module tb_tt_sel_driver;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;
   logic       req_valid = 1'b0;
   logic [9:0] req_addr = '0;
   logic       req_ena = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic       m_ready, m_busy, m_done, m_rst_n, m_inc, m_ena;

   always #5 clk = ~clk;

   tt_sel_driver_if #(.ADDR_W(10)) a_if ();
   tt_sel_driver_if #(.ADDR_W(4))  b_if ();

   assign a_if.req_valid = req_valid && !sel;
   assign a_if.req_addr  = req_addr;
   assign a_if.req_ena   = req_ena;
   assign b_if.req_valid = req_valid && sel;
   assign b_if.req_addr  = req_addr[3:0];
   assign b_if.req_ena   = req_ena;

   tt_sel_driver #(.ADDR_W(10), .PULSE_CYC(4)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   tt_sel_driver #(.ADDR_W(4),  .PULSE_CYC(1)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

   assign m_ready = sel ? b_if.req_ready      : a_if.req_ready;
   assign m_busy  = sel ? b_if.busy           : a_if.busy;
   assign m_done  = sel ? b_if.done           : a_if.done;
   assign m_rst_n = sel ? b_if.ctrl_sel_rst_n : a_if.ctrl_sel_rst_n;
   assign m_inc   = sel ? b_if.ctrl_sel_inc   : a_if.ctrl_sel_inc;
   assign m_ena   = sel ? b_if.ctrl_ena       : a_if.ctrl_ena;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // pad protocol: no increment during counter reset, no enable while a sequence runs
   always @(negedge clk) begin
      if (!rst) begin
         if (a_if.ctrl_sel_inc && !a_if.ctrl_sel_rst_n) begin n_err++; $display("FAIL proto_inc_rst_a t=%0t", $time); end
         if (b_if.ctrl_sel_inc && !b_if.ctrl_sel_rst_n) begin n_err++; $display("FAIL proto_inc_rst_b t=%0t", $time); end
         if (a_if.ctrl_ena && a_if.busy) begin n_err++; $display("FAIL proto_ena_busy_a t=%0t", $time); end
         if (b_if.ctrl_ena && b_if.busy) begin n_err++; $display("FAIL proto_ena_busy_b t=%0t", $time); end
      end
   end

   task automatic run_req(input bit s, input int addr, input bit ena, input int p, input int exp_lat);
      int lat, fall, rise, first, model, hi_run, lo_run;
      bit prev_inc, prev_rst_n;
      @(negedge clk);
      sel = s;
      #1;
      chk("ready_before", m_ready, 1);
      req_addr  = 10'(addr);
      req_ena   = ena;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("busy_at_accept", m_busy, 1);
      chk("ready_at_accept", m_ready, 0);
      chk("ena_at_accept", m_ena, 0);
      lat = -1; fall = -1; rise = -1; first = -1; model = 99; hi_run = 0; lo_run = 0;
      prev_inc = m_inc; prev_rst_n = m_rst_n;
      for (int c = 0; c < exp_lat + 20; c++) begin
         if (c > 0) @(negedge clk);
         if (!m_rst_n && prev_rst_n && fall < 0) fall = c;
         if (m_rst_n && !prev_rst_n && fall >= 0 && rise < 0) rise = c;
         // on-chip select counter: cleared while sel_rst_n is low, counts inc rising edges
         if (!m_rst_n) model = 0;
         else if (m_inc && !prev_inc) begin
            model++;
            if (first < 0) first = c;
            else chk("inc_low_width", lo_run, p);
         end
         if (m_inc) hi_run++;
         else if (prev_inc) begin
            chk("inc_high_width", hi_run, p);
            hi_run = 0;
         end
         lo_run = m_inc ? 0 : lo_run + 1;
         prev_inc = m_inc; prev_rst_n = m_rst_n;
         if (m_done) begin lat = c; break; end
      end
      chk("latency", lat, exp_lat);
      chk("select_count", model, addr);
      chk("ena_at_done", m_ena, ena);
      chk("busy_at_done", m_busy, 0);
      chk("ready_at_done", m_ready, 1);
      chk("selrst_fall", fall, p);
      chk("selrst_rise", rise, 2 * p);
      if (addr > 0) chk("first_inc", first, 3 * p);
      @(negedge clk);
      chk("done_one_cycle", m_done, 0);
      chk("ena_hold", m_ena, ena);
      chk("rst_n_idle", m_rst_n, 1);
   endtask

   typedef struct {
      bit s;
      int addr;
      bit ena;
      int p;
      int lat;
   } vec_t;

   initial begin
      vec_t tv[8];
      int lat, dcnt, ra;
      bit rs, re;
      tv[0] = '{0, 5,    1, 4, 52};
      tv[1] = '{0, 0,    1, 4, 12};
      tv[2] = '{0, 2,    0, 4, 28};
      tv[3] = '{0, 1023, 1, 4, 8196};
      tv[4] = '{1, 15,   1, 1, 33};
      tv[5] = '{1, 0,    0, 1, 3};
      tv[6] = '{1, 1,    1, 1, 5};
      tv[7] = '{0, 1,    0, 4, 20};
      // reset values on both instances
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         sel = k[0];
         #1;
         chk("rst_sel_rst_n", m_rst_n, 0);
         chk("rst_inc", m_inc, 0);
         chk("rst_ena", m_ena, 0);
         chk("rst_ready", m_ready, 1);
         chk("rst_busy", m_busy, 0);
         chk("rst_done", m_done, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) run_req(tv[i].s, tv[i].addr, tv[i].ena, tv[i].p, tv[i].lat);
      // back-to-back: second request held while busy, accepted on the edge after done
      @(negedge clk);
      sel = 1'b0; req_addr = 10'd3; req_ena = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      req_addr = 10'd1; req_ena = 1'b0;
      lat = -1;
      for (int c = 0; c < 60; c++) begin
         if (c > 0) @(negedge clk);
         if (m_done) begin lat = c; break; end
      end
      chk("b2b_lat1", lat, 36);
      chk("b2b_ena1", m_ena, 1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_accept_busy", m_busy, 1);
      chk("b2b_accept_done", m_done, 0);
      chk("b2b_accept_ena", m_ena, 0);
      lat = -1;
      for (int c = 0; c < 60; c++) begin
         if (c > 0) @(negedge clk);
         if (m_done) begin lat = c; break; end
      end
      chk("b2b_lat2", lat, 20);
      chk("b2b_ena2", m_ena, 0);
      repeat (3) @(negedge clk);
      chk("b2b_ena2_hold", m_ena, 0);
      // asynchronous reset during an increment pulse
      sel = 1'b0; req_addr = 10'd5; req_ena = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (12) @(negedge clk);
      chk("pre_abort_inc", m_inc, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_inc", m_inc, 0);
      chk("abort_sel_rst_n", m_rst_n, 0);
      chk("abort_ena", m_ena, 0);
      chk("abort_ready", m_ready, 1);
      chk("abort_busy", m_busy, 0);
      chk("abort_done", m_done, 0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (m_done) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
      chk("abort_idle_busy", m_busy, 0);
      run_req(0, 5, 1, 4, 52);
      // random requests on both instances under the protocol monitor
      for (int i = 0; i < 8; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = int'($urandom_range(0, 7));
         re = 1'($urandom_range(0, 1));
         run_req(rs, ra, re, rs ? 1 : 4, (3 + 2 * ra) * (rs ? 1 : 4));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
